// File: rtl/nanosoc_ahb_bootcopy_initiator.sv
// nanosoc_ahb_bootcopy_initiator: non-pipelined AHB-Lite word copy engine using single NONSEQ transfers.
// Define NANOSOC_BOOTCOPY_VERIFY_EN to read back and compare every written word.
module nanosoc_ahb_bootcopy_initiator #(
    parameter int SYS_ADDR_W = 32,
    parameter int SYS_DATA_W = 32,
    parameter int COUNT_W    = 10
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  START,
    input  logic [SYS_ADDR_W-1:0] SRC_ADDR,
    input  logic [SYS_ADDR_W-1:0] DST_ADDR,
    input  logic [COUNT_W-1:0]    WORD_COUNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [SYS_ADDR_W-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HWRITE,
    output logic [SYS_DATA_W-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [SYS_DATA_W-1:0] HRDATA,
    input  logic                  HRESP
);
    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA
`ifdef NANOSOC_BOOTCOPY_VERIFY_EN
        , VF_ADDR, VF_DATA
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [SYS_ADDR_W-1:0] src_q, src_d, dst_q, dst_d, haddr_q, haddr_d, src_nxt;
    logic [COUNT_W-1:0]    rem_q, rem_d;
    logic [SYS_DATA_W-1:0] buf_q, buf_d;
    logic                  hwrite_q, hwrite_d, done_q, done_d, error_q, error_d;
    logic                  data_ok, err_end, adv, fail, last, addr_ph;

    assign data_ok = HREADY && !HRESP;
    assign err_end = HREADY && HRESP;
    assign src_nxt = src_q + SYS_ADDR_W'(4);
    assign last    = rem_q == COUNT_W'(1);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        buf_d    = buf_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        done_d   = 1'b0;
        error_d  = error_q;
        adv      = 1'b0;
        fail     = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                error_d = 1'b0;
                if (WORD_COUNT == '0) done_d = 1'b1;
                else begin
                    src_d    = {SRC_ADDR[SYS_ADDR_W-1:2], 2'b00};
                    dst_d    = {DST_ADDR[SYS_ADDR_W-1:2], 2'b00};
                    rem_d    = WORD_COUNT;
                    haddr_d  = {SRC_ADDR[SYS_ADDR_W-1:2], 2'b00};
                    hwrite_d = 1'b0;
                    state_d  = RD_ADDR;
                end
            end
            RD_ADDR: state_d = HREADY ? RD_DATA : RD_ADDR;
            RD_DATA: begin
                fail = err_end;
                if (data_ok) begin
                    buf_d    = HRDATA;
                    haddr_d  = dst_q;
                    hwrite_d = 1'b1;
                    state_d  = WR_ADDR;
                end
            end
            WR_ADDR: state_d = HREADY ? WR_DATA : WR_ADDR;
`ifdef NANOSOC_BOOTCOPY_VERIFY_EN
            WR_DATA: begin
                fail = err_end;
                if (data_ok) begin
                    hwrite_d = 1'b0;
                    state_d  = VF_ADDR;
                end
            end
            VF_ADDR: state_d = HREADY ? VF_DATA : VF_ADDR;
            VF_DATA: begin
                fail = err_end || (data_ok && HRDATA != buf_q);
                adv  = data_ok && HRDATA == buf_q;
            end
`else
            WR_DATA: begin
                fail = err_end;
                adv  = data_ok;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (adv) begin
            src_d   = src_nxt;
            dst_d   = dst_q + SYS_ADDR_W'(4);
            rem_d   = rem_q - 1'b1;
            done_d  = last;
            state_d = last ? IDLE : RD_ADDR;
            // bus address stays put after the final word to avoid a pointless toggle
            if (!last) begin
                haddr_d  = src_nxt;
                hwrite_d = 1'b0;
            end
        end
        if (fail) begin
            state_d = IDLE;
            done_d  = 1'b1;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            buf_q    <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            buf_q    <= buf_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

`ifdef NANOSOC_BOOTCOPY_VERIFY_EN
    assign addr_ph = state_q == RD_ADDR || state_q == WR_ADDR || state_q == VF_ADDR;
`else
    assign addr_ph = state_q == RD_ADDR || state_q == WR_ADDR;
`endif

    assign BUSY   = state_q != IDLE;
    assign DONE   = done_q;
    assign ERROR  = error_q;
    assign HADDR  = haddr_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = buf_q;
    assign HTRANS = addr_ph ? 2'b10 : 2'b00;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;
endmodule

// File: tb/tb_nanosoc_ahb_bootcopy_initiator.sv
// tb_nanosoc_ahb_bootcopy_initiator: table of copy jobs run against an AHB memory model
// with configurable wait states, two-cycle error injection and write corruption.
`timescale 1ns/1ps
module tb_nanosoc_ahb_bootcopy_initiator;
`ifdef NANOSOC_BOOTCOPY_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic        HCLK, HRESETn, START;
    logic [31:0] SRC_ADDR, DST_ADDR;
    logic [9:0]  WORD_COUNT;
    logic        BUSY, DONE, ERROR;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE, HREADY, HRESP;

    nanosoc_ahb_bootcopy_initiator dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .START(START),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .WORD_COUNT(WORD_COUNT),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          cnt;
        int          waits;
        logic        err_en;
        logic [31:0] err_addr;
        logic        cor_en;
        logic [31:0] cor_addr;
        int          restart;
        int          exp_cyc;
        logic        exp_err;
        int          exp_rd;
        int          exp_wr;
        logic        chk_data;
    } vec_t;

    logic [31:0] mem [4096];
    int          wgen [4096];
    int          gen = 0, waits = 0;
    logic        err_en = 1'b0, cor_en = 1'b0;
    logic [31:0] err_addr = '0, cor_addr = '0;
    int          n_rd = 0, n_wr = 0, viol = 0;
    logic [31:0] rd_log [8];
    logic        ph_valid, ph_write, ph_err, err_stage, ph_first;
    logic [31:0] ph_addr, ph_wdata;
    int          wcnt;
    int          n_chk = 0, n_fail = 0;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'hC3A5_0F1E;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'({a[31:28], a[9:2]});
    endfunction

    assign HREADY = !ph_valid || (ph_err ? err_stage : (wcnt == 0));
    assign HRESP  = ph_valid && ph_err;
    assign HRDATA = (wgen[idx(ph_addr)] == gen) ? mem[idx(ph_addr)] : pattern(ph_addr);

    // memory responder plus bus-rule monitor
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ph_valid <= 1'b0; ph_write <= 1'b0; ph_err <= 1'b0; err_stage <= 1'b0;
            ph_first <= 1'b0; ph_addr <= '0; ph_wdata <= '0; wcnt <= 0;
        end else begin
            if (HTRANS != 2'b00 && HTRANS != 2'b10) viol <= viol + 1;
            if (HTRANS == 2'b10 && {HSIZE, HBURST, HPROT} != 10'b010_000_0011) viol <= viol + 1;
            if (ph_valid) begin
                if (HTRANS != 2'b00 || HADDR != ph_addr || HWRITE != ph_write) viol <= viol + 1;
                if (ph_write && !ph_first && HWDATA != ph_wdata) viol <= viol + 1;
                if (ph_first) ph_wdata <= HWDATA;
                ph_first <= 1'b0;
                if (wcnt > 0) wcnt <= wcnt - 1;
                if (ph_err) err_stage <= 1'b1;
                if (HREADY) begin
                    ph_valid <= 1'b0;
                    if (ph_write && !ph_err) begin
                        mem[idx(ph_addr)]  <= (cor_en && ph_addr == cor_addr) ? HWDATA ^ 32'h1 : HWDATA;
                        wgen[idx(ph_addr)] <= gen;
                        n_wr <= n_wr + 1;
                    end
                end
            end
            if (HREADY && HTRANS == 2'b10) begin
                ph_valid  <= 1'b1;
                ph_addr   <= HADDR;
                ph_write  <= HWRITE;
                ph_first  <= 1'b1;
                wcnt      <= waits;
                ph_err    <= err_en && HWRITE && HADDR == err_addr;
                err_stage <= 1'b0;
                if (!HWRITE) begin
                    rd_log[n_rd % 8] <= HADDR;
                    n_rd <= n_rd + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, busy_bad, bad, b_rd, b_wr, b_vi;
        logic seen;
        logic [31:0] a;
        gen++;
        waits = v.waits; err_en = v.err_en; err_addr = v.err_addr;
        cor_en = v.cor_en; cor_addr = v.cor_addr;
        b_rd = n_rd; b_wr = n_wr; b_vi = viol;
        @(negedge HCLK);
        SRC_ADDR = v.src; DST_ADDR = v.dst; WORD_COUNT = 10'(v.cnt); START = 1'b1;
        cyc = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && cyc < 500) begin
            @(negedge HCLK);
            cyc++;
            if (cyc == 1) START = 1'b0;
            if (cyc == v.restart) begin
                START = 1'b1; SRC_ADDR = 32'h300; DST_ADDR = 32'h400; WORD_COUNT = 10'd7;
            end else if (cyc == v.restart + 1) START = 1'b0;
            if (DONE) seen = 1'b1;
            else if (!BUSY) busy_bad++;
        end
        START = 1'b0;
        chk("done_cycle", cyc, v.exp_cyc);
        chk("busy_at_done", BUSY, 0);
        chk("busy_during_copy", busy_bad, 0);
        chk("error_at_done", ERROR, v.exp_err);
        @(negedge HCLK);
        chk("done_one_cycle", DONE, 0);
        repeat (3) @(negedge HCLK);
        chk("error_sticky", ERROR, v.exp_err);
        chk("read_transfers", n_rd - b_rd, v.exp_rd);
        chk("write_transfers", n_wr - b_wr, v.exp_wr);
        chk("bus_rules", viol - b_vi, 0);
        if (v.chk_data) begin
            bad = 0;
            for (int i = 0; i < v.cnt; i++) begin
                a = v.dst + 32'(4 * i);
                if (wgen[idx(a)] != gen || mem[idx(a)] != pattern(v.src + 32'(4 * i))) bad++;
            end
            chk("dest_data", bad, 0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vec_t wv;
        logic [31:0] wexp [3];
        int base, cyc;
        HRESETn = 1'b1; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0; WORD_COUNT = '0;
        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("fixed_ctrl", {HSIZE, HBURST, HPROT}, 10'b010_000_0011);
        HRESETn = 1'b1;

        vecs[0] = '{32'h0, 32'h2000_0000, 4, 0, 1'b0, 32'h0, 1'b0, 32'h0, -1,
                    V ? 25 : 17, 1'b0, V ? 8 : 4, 4, 1'b1};
        vecs[1] = '{32'h0, 32'h2000_0000, 4, 3, 1'b0, 32'h0, 1'b0, 32'h0, -1,
                    V ? 61 : 41, 1'b0, V ? 8 : 4, 4, 1'b1};
        vecs[2] = '{32'h0, 32'h2000_0000, 4, 0, 1'b1, 32'h2000_0004, 1'b0, 32'h0, -1,
                    V ? 12 : 10, 1'b1, V ? 3 : 2, 1, 1'b0};
        vecs[3] = '{32'h40, 32'h80, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, -1,
                    1, 1'b0, 0, 0, 1'b0};
        vecs[4] = '{32'h100, 32'h200, 2, 0, 1'b0, 32'h0, 1'b0, 32'h0, 3,
                    V ? 13 : 9, 1'b0, V ? 4 : 2, 2, 1'b1};
        vecs[5] = '{32'h0, 32'h2000_0000, 4, 0, 1'b0, 32'h0, 1'b1, 32'h2000_0008, -1,
                    V ? 19 : 17, V ? 1'b1 : 1'b0, V ? 6 : 4, V ? 3 : 4, 1'b0};
        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        wv = '{32'hFFFF_FFF8, 32'h3000_0000, 3, 1, 1'b0, 32'h0, 1'b0, 32'h0, -1,
               V ? 28 : 19, 1'b0, V ? 6 : 3, 3, 1'b1};
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        base = n_rd;
        run_vec(wv);
        for (int i = 0; i < 3; i++) chk("wrap_read_addr", rd_log[(base + i * (V + 1)) % 8], wexp[i]);

        gen++; waits = 3; err_en = 1'b0; cor_en = 1'b0;
        @(negedge HCLK);
        SRC_ADDR = 32'h0; DST_ADDR = 32'h2000_0000; WORD_COUNT = 10'd2; START = 1'b1;
        @(negedge HCLK);
        START = 1'b0;
        cyc = 0;
        while (!(ph_valid && ph_write) && cyc < 100) begin
            @(negedge HCLK);
            cyc++;
        end
        chk("reach_write_data", cyc < 100, 1);
        chk("busy_before_reset", BUSY, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_rst_htrans", HTRANS, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_haddr", HADDR, 0);
        chk("async_rst_hwrite", HWRITE, 0);
        chk("async_rst_hwdata", HWDATA, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        chk("post_rst_idle", {BUSY, DONE, HTRANS}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
